// File: rtl/muldiv_seq.sv
// Iterative RV64 multiply/divide sequencer: radix-2 shift-add MUL, restoring DIV/REM.
// Optional macro MULDIV_EARLY_OUT_EN ends MUL as soon as the remaining multiplier is zero.
module muldiv_seq #(
    parameter int WBSEL_WIDTH = 3,
    parameter int XLEN        = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [XLEN-1:0]        req_a,
    input  logic [XLEN-1:0]        req_b,
    input  logic                   flush,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [XLEN-1:0]        resp_data,
    output logic [WBSEL_WIDTH-1:0] resp_wbsel,
    output logic                   busy
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic [2:0]      op;
    logic [XLEN-1:0] acc, mcand, mplier;
    logic [XLEN-1:0] rem, quo, divisor;
    logic            neg_q, neg_r;

    logic            is_signed, is_div, is_rem, ge;
    logic [XLEN-1:0] a_mag, b_mag, rem_sub, quo_fix, rem_fix;
    logic [XLEN:0]   rem_sh;

    function automatic logic [WBSEL_WIDTH-1:0] wbsel_of(input logic [2:0] o);
        case (o)
            3'd0:       return WBSEL_WIDTH'(7);
            3'd1, 3'd2: return WBSEL_WIDTH'(5);
            3'd3, 3'd4: return WBSEL_WIDTH'(6);
            default:    return '0;
        endcase
    endfunction

    always_comb begin
        is_signed = (req_op == 3'd1) || (req_op == 3'd3);
        is_div    = (op == 3'd1) || (op == 3'd2);
        is_rem    = (op == 3'd3) || (op == 3'd4);
        a_mag     = (is_signed && req_a[XLEN-1]) ? -req_a : req_a;
        b_mag     = (is_signed && req_b[XLEN-1]) ? -req_b : req_b;
        // one restoring step: shift the quotient MSB into the partial remainder
        rem_sh    = {rem, quo[XLEN-1]};
        ge        = rem_sh >= {1'b0, divisor};
        rem_sub   = rem_sh[XLEN-1:0] - divisor;
        quo_fix   = neg_q ? -quo : quo;
        rem_fix   = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            op         <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_wbsel <= '0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
        end else if (flush && state != IDLE) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req_valid && !flush) begin
                    op        <= req_op;
                    counter   <= '0;
                    busy      <= 1'b1;
                    req_ready <= 1'b0;
                    if (req_op == 3'd0) begin
                        state  <= MUL_RUN;
                        acc    <= '0;
                        mcand  <= req_a;
                        mplier <= req_b;
                    end else begin
                        // special cases park in DIV_RUN with the counter at its end,
                        // so the next edge finishes them with no sign fix
                        state   <= DIV_RUN;
                        divisor <= b_mag;
                        rem     <= '0;
                        quo     <= a_mag;
                        neg_q   <= is_signed && (req_a[XLEN-1] ^ req_b[XLEN-1]);
                        neg_r   <= is_signed && req_a[XLEN-1];
                        if (req_op > 3'd4) begin
                            quo     <= '0;
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
                            counter <= LAST;
                        end else if (req_b == '0) begin
                            quo     <= '1;
                            rem     <= req_a;
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
                            counter <= LAST;
                        end else if (is_signed && req_a == MIN_NEG && req_b == '1) begin
                            quo     <= req_a;
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
                            counter <= LAST;
                        end
                    end
                end
                MUL_RUN: begin
`ifdef MULDIV_EARLY_OUT_EN
                    if (mplier == '0) begin
`else
                    if (counter == LAST) begin
`endif
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_data  <= acc;
                        resp_wbsel <= wbsel_of(op);
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        counter <= counter + 1'b1;
                    end
                end
                DIV_RUN: begin
                    if (counter == LAST) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_data  <= is_div ? quo_fix : (is_rem ? rem_fix : '0);
                        resp_wbsel <= wbsel_of(op);
                    end else begin
                        rem     <= ge ? rem_sub : rem_sh[XLEN-1:0];
                        quo     <= {quo[XLEN-2:0], ge};
                        counter <= counter + 1'b1;
                    end
                end
                DONE: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
